// File: rtl/cpu_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_bus_ctrl
// Function : Multi-beat transfer engine between the CPU core and a four-phase
//            strobe/ready memory bus, with per-phase timeout abort.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_bus_ctrl #(
    parameter int  ADDR_W      = 32,
    parameter int  DATA_W      = 8,
    parameter int  MAX_BEATS   = 4,
    parameter int  TIMEOUT_CYC = 255,
    localparam int SZ_W        = $clog2(MAX_BEATS + 1)
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_req,
    input  logic                        i_we,
    input  logic                        i_dir,
    input  logic [ADDR_W-1:0]           i_addr,
    input  logic [SZ_W-1:0]             i_size,
    input  logic [DATA_W*MAX_BEATS-1:0] i_wdata,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_err,
    output logic [DATA_W*MAX_BEATS-1:0] o_rdata,
    output logic                        o_bus_clk,
    output logic                        o_bus_we,
    output logic [ADDR_W-1:0]           o_bus_addr,
    output logic [DATA_W-1:0]           o_bus_data,
    input  logic [DATA_W-1:0]           i_bus_data,
    input  logic                        i_bus_data_ready
);

    localparam int CNT_W            = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int c_TO_LAST_INT    = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
    localparam logic [CNT_W-1:0] c_TO_LAST = CNT_W'(c_TO_LAST_INT);
    localparam logic             c_TO_EN   = (TIMEOUT_CYC > 0);
    localparam logic [SZ_W-1:0]  c_MAX_SZ  = SZ_W'(MAX_BEATS);
    localparam logic [SZ_W-1:0]  c_ONE_SZ  = SZ_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_STROBE  = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t                      r_state,    w_state_nxt;
    logic [SZ_W-1:0]             r_beat,     w_beat_nxt;
    logic [CNT_W-1:0]            r_cnt,      w_cnt_nxt;
    logic                        r_we,       w_we_nxt;
    logic                        r_dir,      w_dir_nxt;
    logic [SZ_W-1:0]             r_size,     w_size_nxt;
    logic [DATA_W*MAX_BEATS-1:0] r_wdata,    w_wdata_nxt;
    logic                        r_busy,     w_busy_nxt;
    logic                        r_done,     w_done_nxt;
    logic                        r_err,      w_err_nxt;
    logic [DATA_W*MAX_BEATS-1:0] r_rdata,    w_rdata_nxt;
    logic                        r_bus_clk,  w_bus_clk_nxt;
    logic                        r_bus_we,   w_bus_we_nxt;
    logic [ADDR_W-1:0]           r_bus_addr, w_bus_addr_nxt;
    logic [DATA_W-1:0]           r_bus_data, w_bus_data_nxt;

    logic [SZ_W-1:0]             w_beat_inc;
    logic [DATA_W-1:0]           w_next_lane;
    logic                        w_to_hit;

    always_comb begin
        w_state_nxt    = r_state;
        w_beat_nxt     = r_beat;
        w_cnt_nxt      = '0;
        w_we_nxt       = r_we;
        w_dir_nxt      = r_dir;
        w_size_nxt     = r_size;
        w_wdata_nxt    = r_wdata;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_err_nxt      = 1'b0;
        w_rdata_nxt    = r_rdata;
        w_bus_clk_nxt  = r_bus_clk;
        w_bus_we_nxt   = r_bus_we;
        w_bus_addr_nxt = r_bus_addr;
        w_bus_data_nxt = r_bus_data;
        w_beat_inc     = r_beat + c_ONE_SZ;
        w_next_lane    = '0;
        w_to_hit       = c_TO_EN && (r_cnt == c_TO_LAST);

        for (int k = 0; k < MAX_BEATS; k++) begin
            if (w_beat_inc == SZ_W'(k)) begin
                w_next_lane = r_wdata[k*DATA_W +: DATA_W];
            end
        end

        case (r_state)
            S_IDLE: begin
                // The cycle carrying o_done is deliberately dead so the core sees completion first
                if (i_req && !r_done) begin
                    w_we_nxt       = i_we;
                    w_dir_nxt      = i_dir;
                    w_wdata_nxt    = i_wdata;
                    if (i_size == '0) begin
                        w_size_nxt = c_ONE_SZ;
                    end else if (i_size > c_MAX_SZ) begin
                        w_size_nxt = c_MAX_SZ;
                    end else begin
                        w_size_nxt = i_size;
                    end
                    w_rdata_nxt    = '0;
                    w_busy_nxt     = 1'b1;
                    w_beat_nxt     = '0;
                    w_bus_addr_nxt = i_addr;
                    w_bus_we_nxt   = i_we;
                    w_bus_data_nxt = i_wdata[DATA_W-1:0];
                    w_bus_clk_nxt  = 1'b1;
                    w_state_nxt    = S_STROBE;
                end
            end

            S_STROBE: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (i_bus_data_ready) begin
                    if (!r_we) begin
                        for (int k = 0; k < MAX_BEATS; k++) begin
                            if (r_beat == SZ_W'(k)) begin
                                w_rdata_nxt[k*DATA_W +: DATA_W] = i_bus_data;
                            end
                        end
                    end
                    w_bus_clk_nxt = 1'b0;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = S_RELEASE;
                end else if (w_to_hit) begin
                    w_bus_clk_nxt = 1'b0;
                    w_busy_nxt    = 1'b0;
                    w_done_nxt    = 1'b1;
                    w_err_nxt     = 1'b1;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = S_IDLE;
                end
            end

            S_RELEASE: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (!i_bus_data_ready) begin
                    w_cnt_nxt = '0;
                    if (w_beat_inc < r_size) begin
                        w_beat_nxt     = w_beat_inc;
                        w_bus_addr_nxt = r_dir ? (r_bus_addr - ADDR_W'(1))
                                               : (r_bus_addr + ADDR_W'(1));
                        w_bus_data_nxt = w_next_lane;
                        w_bus_clk_nxt  = 1'b1;
                        w_state_nxt    = S_STROBE;
                    end else begin
                        w_busy_nxt     = 1'b0;
                        w_done_nxt     = 1'b1;
                        w_state_nxt    = S_IDLE;
                    end
                end else if (w_to_hit) begin
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_err_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_beat     <= '0;
            r_cnt      <= '0;
            r_we       <= 1'b0;
            r_dir      <= 1'b0;
            r_size     <= '0;
            r_wdata    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
            r_bus_clk  <= 1'b0;
            r_bus_we   <= 1'b0;
            r_bus_addr <= '0;
            r_bus_data <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_beat     <= w_beat_nxt;
            r_cnt      <= w_cnt_nxt;
            r_we       <= w_we_nxt;
            r_dir      <= w_dir_nxt;
            r_size     <= w_size_nxt;
            r_wdata    <= w_wdata_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_rdata    <= w_rdata_nxt;
            r_bus_clk  <= w_bus_clk_nxt;
            r_bus_we   <= w_bus_we_nxt;
            r_bus_addr <= w_bus_addr_nxt;
            r_bus_data <= w_bus_data_nxt;
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_err      = r_err;
    assign o_rdata    = r_rdata;
    assign o_bus_clk  = r_bus_clk;
    assign o_bus_we   = r_bus_we;
    assign o_bus_addr = r_bus_addr;
    assign o_bus_data = r_bus_data;

endmodule
`default_nettype wire
